// File: rtl/tt_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tt_scan_ctrl
//
// Purpose:
//   Steps the select inputs of a mux-based truth-table block through every
//   input combination. For each row it samples the block's output Y. It
//   assembles the measured table and compares it against an expected table
//   that is latched when the scan starts.
//
// Parameters:
//   N_IN    - number of function inputs driven (ROWS = 2**N_IN)
//   SETTLE  - idle cycles per row before Y is sampled (0..15)
//   SEL_REV - 1 = sel_out bit order reversed (row bit 0 -> sel_out[N_IN-1])
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a scan (accepted only when idle)
//   abort        in   cancel a running scan
//   expected     in   [ROWS]   expected table, bit i = Y of row i
//   y_in         in   output Y of the function under scan
//   sel_out      out  [N_IN]   drives the function inputs
//   busy         out  high while a scan is in progress
//   done         out  one-cycle pulse when a scan completes
//   result       out  [ROWS]   measured table
//   pass         out  measured table equals the latched expected table
//   mismatch_cnt out  [N_IN+1] number of differing rows
//   first_fail   out  [N_IN]   lowest mismatching row
//   fail_valid   out  at least one row mismatched
// ---------------------------------------------------------------------------
module tt_scan_ctrl #(
  parameter int N_IN    = 3,
  parameter int SETTLE  = 1,
  parameter bit SEL_REV = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(2**N_IN)-1:0]   expected,
  input  logic                   y_in,
  output logic [N_IN-1:0]        sel_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   result,
  output logic                   pass,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid
);

  localparam int ROWS = 2**N_IN;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [N_IN-1:0]     r_row;
  logic [3:0]          r_cnt;
  logic [ROWS-1:0]     r_exp;
  logic [N_IN-1:0]     r_sel;
  logic                r_busy;
  logic                r_done;
  logic [ROWS-1:0]     r_result;
  logic                r_pass;
  logic [N_IN:0]       r_mmCnt;
  logic [N_IN-1:0]     r_firstFail;
  logic                r_failValid;

  logic                w_rowMiss;
  logic [N_IN:0]       w_mmNext;
  logic [N_IN-1:0]     w_rowNext;

  // Row index to select pattern; reversal supports tables wired MSB-first.
  function automatic logic [N_IN-1:0] mapSel(input logic [N_IN-1:0] row);
    logic [N_IN-1:0] rev;
    rev = '0;
    for (int i = 0; i < N_IN; i++) begin
      rev[i] = row[N_IN-1-i];
    end
    return SEL_REV ? rev : row;
  endfunction

  assign w_rowMiss = (y_in != r_exp[r_row]);
  assign w_mmNext  = r_mmCnt + (N_IN+1)'(w_rowMiss);
  assign w_rowNext = r_row + N_IN'(1);

  // Single sequencer: every output is a register. sel_out and busy are
  // loaded on the edge that enters a row, so they are valid for the whole row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_pass      <= 1'b0;
      r_mmCnt     <= '0;
      r_firstFail <= '0;
      r_failValid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel  <= '0;
          r_busy <= 1'b0;
          // abort has priority over start even when the controller is idle
          if (start && !abort) begin
            r_exp       <= expected;
            r_result    <= '0;
            r_mmCnt     <= '0;
            r_firstFail <= '0;
            r_failValid <= 1'b0;
            r_pass      <= 1'b0;
            r_row       <= '0;
            r_cnt       <= SETTLE_L;
            r_sel       <= mapSel('0);
            r_busy      <= 1'b1;
            r_state     <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_result[r_row] <= y_in;
            r_mmCnt         <= w_mmNext;
            if (w_rowMiss && !r_failValid) begin
              r_firstFail <= r_row;
              r_failValid <= 1'b1;
            end
            if (r_row == LAST_ROW) begin
              // pass includes the row sampled on this same edge
              r_pass  <= (w_mmNext == '0);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_sel   <= '0;
              r_state <= S_DONE;
            end else begin
              r_row   <= w_rowNext;
              r_cnt   <= SETTLE_L;
              r_sel   <= mapSel(w_rowNext);
              r_state <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel_out      = r_sel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign pass         = r_pass;
  assign mismatch_cnt = r_mmCnt;
  assign first_fail   = r_firstFail;
  assign fail_valid   = r_failValid;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_scan_ctrl
//
// Purpose:
//   Self-checking bench for tt_scan_ctrl. Two instances are used:
//     A: default build (N_IN=3, SETTLE=1, SEL_REV=0)
//     B: SETTLE=0, SEL_REV=1, with the function wired in reverse order
//   Each instance scans a truth table held in the bench. The expected
//   outputs are derived from whole-table arithmetic: XOR masks, popcount
//   and lowest set bit.
// ---------------------------------------------------------------------------
module tb_tt_scan_ctrl;

  logic       clk;
  logic       rst_n;

  logic       startA, abortA, yA;
  logic [7:0] expA, funcA;
  logic [2:0] selA;
  logic       busyA, doneA, passA, fvA;
  logic [7:0] resultA;
  logic [3:0] mmA;
  logic [2:0] ffA;

  logic       startB, abortB, yB;
  logic [7:0] expB, funcB;
  logic [2:0] selB;
  logic       busyB, doneB, passB, fvB;
  logic [7:0] resultB;
  logic [3:0] mmB;
  logic [2:0] ffB;

  int checks;
  int failures;

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // The functions under scan: A in natural order, B with A on sel_out[2].
  assign yA = funcA[selA];
  assign yB = funcB[rev3(selB)];

  tt_scan_ctrl #(.N_IN(3), .SETTLE(1), .SEL_REV(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .abort(abortA),
    .expected(expA), .y_in(yA), .sel_out(selA), .busy(busyA),
    .done(doneA), .result(resultA), .pass(passA),
    .mismatch_cnt(mmA), .first_fail(ffA), .fail_valid(fvA)
  );

  tt_scan_ctrl #(.N_IN(3), .SETTLE(0), .SEL_REV(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB),
    .expected(expB), .y_in(yB), .sel_out(selB), .busy(busyB),
    .done(doneB), .result(resultB), .pass(passB),
    .mismatch_cnt(mmB), .first_fail(ffB), .fail_valid(fvB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int popc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowestSet(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Full result check against a scan of the first 'rows' rows.
  task automatic checkResults(input string who, input logic [7:0] res, input logic [3:0] mm,
                              input logic [2:0] ff, input logic fv, input logic ps,
                              input logic [7:0] f, input logic [7:0] e, input int rows,
                              input logic finished);
    logic [7:0] mask;
    logic [7:0] diff;
    mask = 8'((1 << rows) - 1);
    diff = (f ^ e) & mask;
    checkOutput({who, "_result"}, int'(res), int'(f & mask));
    checkOutput({who, "_mmcnt"}, int'(mm), popc(diff));
    checkOutput({who, "_firstfail"}, int'(ff), lowestSet(diff));
    checkOutput({who, "_failvalid"}, int'(fv), int'(diff != 8'h00));
    checkOutput({who, "_pass"}, int'(ps), int'(finished && diff == 8'h00));
  endtask

  // Scan on instance A. The abort cycle counts busy cycles after the
  // accepting edge, so cycle k belongs to row k/2; -1 means no abort.
  task automatic applyStimulus(input logic [7:0] f, input logic [7:0] e, input int abortCycle);
    funcA  = f;
    expA   = e;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput("A_busy", int'(busyA), 1);
      checkOutput("A_sel", int'(selA), k / 2);
      checkOutput("A_done_early", int'(doneA), 0);
      // scrambled expected and stray starts must not disturb a running scan
      expA   = 8'($urandom);
      startA = 1'($urandom_range(0, 1));
      if (k == abortCycle) begin
        abortA = 1'b1;
        tick();
        abortA = 1'b0;
        startA = 1'b0;
        checkOutput("A_abort_busy", int'(busyA), 0);
        checkOutput("A_abort_sel", int'(selA), 0);
        checkResults("A_abort", resultA, mmA, ffA, fvA, passA, f, e, k / 2, 1'b0);
        for (int j = 0; j < 3; j++) begin
          checkOutput("A_abort_nodone", int'(doneA), 0);
          tick();
        end
        return;
      end
      tick();
    end
    startA = 1'b1;
    checkOutput("A_done", int'(doneA), 1);
    checkOutput("A_done_busy", int'(busyA), 0);
    checkOutput("A_done_sel", int'(selA), 0);
    checkResults("A", resultA, mmA, ffA, fvA, passA, f, e, 8, 1'b1);
    tick();
    startA = 1'b0;
    checkOutput("A_done_pulse", int'(doneA), 0);
    checkOutput("A_start_in_done", int'(busyA), 0);
    checkResults("A_hold", resultA, mmA, ffA, fvA, passA, f, e, 8, 1'b1);
  endtask

  // Scan on instance B (one cycle per row, reversed select order).
  task automatic runScanB(input logic [7:0] f, input logic [7:0] e);
    funcB  = f;
    expB   = e;
    startB = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput("B_busy", int'(busyB), 1);
      checkOutput("B_sel", int'(selB), int'(rev3(3'(k))));
      checkOutput("B_done_early", int'(doneB), 0);
      expB   = 8'($urandom);
      startB = (k == 2);
      tick();
    end
    startB = 1'b0;
    checkOutput("B_done", int'(doneB), 1);
    checkOutput("B_done_busy", int'(busyB), 0);
    checkResults("B", resultB, mmB, ffB, fvB, passB, f, e, 8, 1'b1);
    tick();
    checkOutput("B_done_pulse", int'(doneB), 0);
    checkOutput("B_idle", int'(busyB), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_A"}, int'({selA, busyA, doneA, resultA, passA, mmA, ffA, fvA}), 0);
    checkOutput({tag, "_B"}, int'({selB, busyB, doneB, resultB, passB, mmB, ffB, fvB}), 0);
  endtask

  initial begin
    logic [7:0] f;
    logic [7:0] e;
    int         ab;
    checks   = 0;
    failures = 0;
    startA = 1'b0; abortA = 1'b0; expA = 8'h00; funcA = 8'h96;
    startB = 1'b0; abortB = 1'b0; expB = 8'h00; funcB = 8'h61;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checkAllZero("after_release");

    // start and abort together while idle: abort wins
    startA = 1'b1; abortA = 1'b1;
    tick();
    startA = 1'b0; abortA = 1'b0;
    checkOutput("A_start_abort_idle", int'(busyA), 0);

    // parity function against exact, one-off and inverted tables
    applyStimulus(8'h96, 8'h96, -1);
    applyStimulus(8'h96, 8'h97, -1);
    applyStimulus(8'h96, 8'h69, -1);
    // abort during the SAMPLE cycle of row 3
    applyStimulus(8'h96, 8'h96, 7);
    // reversed wiring, no settle cycles
    runScanB(8'h61, 8'h61);

    // asynchronous reset in the middle of row 5, then a clean scan
    funcA  = 8'h96;
    expA   = 8'h00;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checkOutput("A_row5_sel", int'(selA), 5);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("A_post_reset_idle", int'(busyA), 0);
    applyStimulus(8'h96, 8'h96, -1);

    // randomized scans
    for (int n = 0; n < 24; n++) begin
      f = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       e = f;
        1:       e = f ^ (8'h01 << $urandom_range(0, 7));
        default: e = 8'($urandom);
      endcase
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      applyStimulus(f, e, ab);
      if (n % 3 == 0) runScanB(8'($urandom), ($urandom_range(0, 1) == 1) ? funcB : 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
